// File: rtl/multdiv_seq.sv
// Sequential signed multiply (radix-2 shift-add) / divide (restoring) unit, WIDTH iterations per op.
// Optional build macro MULTDIV_EARLY_OUT_EN: ops with a zero operand complete one edge after start.
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return {WIDTH{1'b0}} - v;
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg_w(v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return {(2*WIDTH){1'b0}} - v;
    endfunction

    logic [1:0]         state_q,  state_d;
    logic               is_div_q, is_div_d;
    logic               sign_q,   sign_d;
    logic               dz_q,     dz_d;
    logic [WIDTH-1:0]   opnd_q,   opnd_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q,    exc_d;
    logic               rdy_q,    rdy_d;

    logic               start_s;
    logic               start_div_s;
    logic               b_zero_s;
    logic               early_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_hi_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic               div_ge_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   fin_res_s;
    logic               fin_exc_s;
    logic               unused_s;

    // MULT has priority when both start pulses arrive together.
    assign start_s     = ctrl_MULT | ctrl_DIV;
    assign start_div_s = ctrl_DIV & ~ctrl_MULT;
    assign b_zero_s    = (data_operandB == {WIDTH{1'b0}});
    assign mag_a_s     = abs_w(data_operandA);
    assign mag_b_s     = abs_w(data_operandB);

`ifdef MULTDIV_EARLY_OUT_EN
    assign early_s = (data_operandA == {WIDTH{1'b0}}) | b_zero_s;
`else
    assign early_s = 1'b0;
`endif

    // Multiply step: upper half accumulates, lower half holds the remaining multiplier bits.
    assign mul_hi_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                      + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_hi_s, acc_q[WIDTH-1:1]};

    // Divide step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign div_shift_s = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_q};
    assign div_ge_s    = ~div_diff_s[WIDTH+1];
    assign div_next_s  = div_ge_s ? {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                  : {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    // Remainder is always below the divisor magnitude, so these top bits never carry information.
    assign unused_s    = div_diff_s[WIDTH] ^ div_shift_s[WIDTH];

    assign prod_s = sign_q ? neg_2w(acc_q) : acc_q;
    assign quo_s  = sign_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];

    // Result and exception selection applied on entry to DONE.
    always_comb begin
        if (is_div_q) begin
            fin_res_s = dz_q ? {WIDTH{1'b0}} : quo_s;
            // A positive quotient with the top bit set only arises from -2^(W-1) / -1.
            fin_exc_s = dz_q | (~sign_q & acc_q[WIDTH-1]);
        end else begin
            fin_res_s = prod_s[WIDTH-1:0];
            fin_exc_s = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
        end
    end

    // Next-state logic: a start pulse always wins, aborting any operation in flight.
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        dz_d     = dz_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (start_s) begin
            state_d  = start_div_s ? ST_DIV : ST_MULT;
            is_div_d = start_div_s;
            sign_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d     = start_div_s & b_zero_s;
            opnd_d   = start_div_s ? mag_b_s : mag_a_s;
            acc_d    = early_s ? {(2*WIDTH){1'b0}}
                               : {{WIDTH{1'b0}}, (start_div_s ? mag_a_s : mag_b_s)};
            cnt_d    = early_s ? CNT_LAST : {CW{1'b0}};
        end else begin
            case (state_q)
                ST_MULT, ST_DIV: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        result_d = fin_res_s;
                        exc_d    = fin_exc_s;
                        rdy_d    = 1'b1;
                    end else begin
                        acc_d = (state_q == ST_DIV) ? div_next_s : mul_next_s;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CW{1'b0}};
            result_q <= {WIDTH{1'b0}};
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            dz_q     <= dz_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: directed cases plus randomized ops against a plain-arithmetic model.
module tb_multdiv_seq;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] op_a  = 32'd0;
    logic [31:0] op_b  = 32'd0;
    logic        ctrl_mult = 1'b0;
    logic        ctrl_div  = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] last_exp_res = 32'd0;
    logic        last_exp_exc = 1'b0;
    exp_t        sb_q[$];

    multdiv_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .ctrl_MULT      (ctrl_mult),
        .ctrl_DIV       (ctrl_div),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Signed 32-bit semantics computed with 64-bit arithmetic.
    function automatic void ref_model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic x);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            r = p[31:0];
            x = (p > 64'sd2147483647) || (p < -(64'sd2147483648));
        end else if (b == 32'd0) begin
            r = 32'd0;
            x = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = a;
            x = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            x = 1'b0;
        end
    endfunction

    // Monitor: every ready pulse must match the oldest expectation, on the expected cycle.
    always @(negedge clock) begin
        if (reset && data_resultRDY) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", data_result, e.res);
                chk("exception", data_exception, e.exc);
                chk("rdy_cycle", cyc, e.due);
                last_exp_res = e.res;
                last_exp_exc = e.exc;
            end
        end
    end

    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        exp_t        e;
        logic [31:0] r;
        logic        x;
        int          lat;
        @(negedge clock);
        ctrl_mult = m;
        ctrl_div  = d;
        op_a      = a;
        op_b      = b;
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        if (push) begin
            ref_model(d && !m, a, b, r, x);
            lat = 33;
`ifdef MULTDIV_EARLY_OUT_EN
            if (a == 32'd0 || b == 32'd0) lat = 1;
`endif
            e.res = r;
            e.exc = x;
            e.due = cyc + lat;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("rdy_timeout", 64'd0, 64'd1);
            sb_q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'($urandom_range(0, 20));
            5: v = 32'd0 - 32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #500_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic        m;
        repeat (3) @(negedge clock);
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", data_exception, 1'b0);
        chk("reset_rdy", data_resultRDY, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 1'b1);            drain();
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1);    drain();
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);            drain();
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);    drain();
        issue(1'b0, 1'b1, 32'd5, 32'd0, 1'b1);                    drain();

        // Abort a MULT by a DIV start ten edges later.
        issue(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
        repeat (9) @(negedge clock);
        issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b1);
        drain();

        // Simultaneous starts; previous result must still be held while busy.
        issue(1'b1, 1'b1, 32'd6, 32'd3, 1'b1);
        repeat (5) @(negedge clock);
        chk("hold_result", data_result, last_exp_res);
        chk("hold_exc", data_exception, last_exp_exc);
        drain();

        // Reset in the middle of a MULT.
        issue(1'b1, 1'b0, 32'd5, 32'd9, 1'b0);
        repeat (14) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midreset_result", data_result, 32'd0);
        chk("midreset_exc", data_exception, 1'b0);
        chk("midreset_rdy", data_resultRDY, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        last_exp_res = 32'd0;
        last_exp_exc = 1'b0;
        repeat (40) @(negedge clock);
        chk("postreset_result", data_result, 32'd0);
        issue(1'b1, 1'b0, 32'd2, 32'd3, 1'b1);
        drain();

        // Randomized ops, some aborted by a later start.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                issue(1'b1, 1'b0, pick_operand() | 32'd1, pick_operand() | 32'd1, 1'b0);
                repeat ($urandom_range(0, 30)) @(negedge clock);
            end
            a = pick_operand();
            b = pick_operand();
            m = 1'($urandom_range(0, 1));
            issue(m, ~m, a, b, 1'b1);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
